// File: rtl/nand2_array_bist_ctrl.sv
// Built-in self-test sequencer for a bank of N nand2 cells sharing broadcast A1/A2 inputs.
// Walks all four input patterns, samples ZN after a settle delay and accumulates mismatches.
module nand2_array_bist_ctrl #(
    parameter int unsigned N          = 4,
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned ERRW       = 8
) (
    input  logic            CLK,
    input  logic            RN,
    input  logic            START,
    input  logic            ABORT,
    output logic [N-1:0]    A1,
    output logic [N-1:0]    A2,
    input  logic [N-1:0]    ZN,
    output logic            BUSY,
    output logic            DONE,
    output logic            PASS,
    output logic [ERRW-1:0] ERRCNT,
    output logic [N-1:0]    FAILMAP,
    inout  wire             VDD,
    inout  wire             VSS
);

    typedef enum logic [2:0] {StIdle, StDrive, StSettle, StSample, StFinish} state_e;

    // Six extra bits hold a popcount of up to 32 mismatches without wrapping.
    localparam int unsigned    SumW       = ERRW + 6;
    localparam logic [ERRW-1:0] ErrMax    = {ERRW{1'b1}};
    localparam logic [3:0]     SettleLoad = 4'(SETTLE_CYC);

    state_e          state_q, state_d;
    logic [1:0]      pat_q, pat_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            a1_q, a1_d;
    logic            a2_q, a2_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [ERRW-1:0] errcnt_q, errcnt_d;
    logic [N-1:0]    failmap_q, failmap_d;

    logic [N-1:0]    mis;
    logic [5:0]      mis_cnt;
    logic [SumW-1:0] err_sum;
    logic [ERRW-1:0] err_sat;
    logic [1:0]      pat_next;
    logic            unused_pwr;

    assign unused_pwr = VDD ^ VSS;

    always_comb begin
        mis     = ZN ^ {N{~(a1_q & a2_q)}};
        mis_cnt = '0;
        for (int i = 0; i < int'(N); i++) begin
            mis_cnt = mis_cnt + 6'(mis[i]);
        end
        err_sum  = SumW'(errcnt_q) + SumW'(mis_cnt);
        err_sat  = (err_sum > SumW'(ErrMax)) ? ErrMax : err_sum[ERRW-1:0];
        pat_next = pat_q + 2'd1;
    end

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        cnt_d     = cnt_q;
        a1_d      = a1_q;
        a2_d      = a2_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        errcnt_d  = errcnt_q;
        failmap_d = failmap_q;

        unique case (state_q)
            StIdle: begin
                if (START) begin
                    state_d   = StDrive;
                    pat_d     = 2'd0;
                    a1_d      = 1'b0;
                    a2_d      = 1'b0;
                    busy_d    = 1'b1;
                    pass_d    = 1'b0;
                    errcnt_d  = '0;
                    failmap_d = '0;
                end
            end
            StDrive: begin
                cnt_d   = SettleLoad;
                state_d = (SETTLE_CYC == 0) ? StSample : StSettle;
            end
            StSettle: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StSample;
                end
            end
            StSample: begin
                failmap_d = failmap_q | mis;
                errcnt_d  = err_sat;
                if (pat_q != 2'd3) begin
                    pat_d   = pat_next;
                    a1_d    = pat_next[1];
                    a2_d    = pat_next[0];
                    state_d = StDrive;
                end else begin
                    state_d = StFinish;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = ((failmap_q | mis) == '0);
                end
            end
            StFinish: begin
                state_d = StIdle;
                pat_d   = 2'd0;
                a1_d    = 1'b0;
                a2_d    = 1'b0;
            end
            default: state_d = StIdle;
        endcase

        // Abort beats every other transition; partial results stay visible.
        if (ABORT && (state_q inside {StDrive, StSettle, StSample})) begin
            state_d   = StIdle;
            pat_d     = 2'd0;
            cnt_d     = 4'd0;
            a1_d      = 1'b0;
            a2_d      = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            pass_d    = 1'b0;
            errcnt_d  = errcnt_q;
            failmap_d = failmap_q;
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q   <= StIdle;
            pat_q     <= 2'd0;
            cnt_q     <= 4'd0;
            a1_q      <= 1'b0;
            a2_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            errcnt_q  <= '0;
            failmap_q <= '0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            cnt_q     <= cnt_d;
            a1_q      <= a1_d;
            a2_q      <= a2_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            errcnt_q  <= errcnt_d;
            failmap_q <= failmap_d;
        end
    end

    assign A1      = {N{a1_q}};
    assign A2      = {N{a2_q}};
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign PASS    = pass_q;
    assign ERRCNT  = errcnt_q;
    assign FAILMAP = failmap_q;

endmodule

// File: tb/tb_nand2_array_bist_ctrl.sv
// Bench for nand2_array_bist_ctrl: two instances (settle 2 / ERRW 8 and settle 0 / ERRW 3)
// checked every cycle against a timing-and-fault model of the BIST run.
module tb_nand2_array_bist_ctrl;

    logic       clk = 1'b0;
    logic       rn  = 1'b0;
    logic [1:0] start = '0;
    logic [1:0] abort = '0;
    logic [3:0] zn0 = '0, zn1 = '0;
    wire        vdd, vss;

    logic [3:0] a1_0, a2_0, fm_0, a1_1, a2_1, fm_1;
    logic       busy_0, done_0, pass_0, busy_1, done_1, pass_1;
    logic [7:0] ec_0;
    logic [2:0] ec_1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    nand2_array_bist_ctrl #(.N(4), .SETTLE_CYC(2), .ERRW(8)) u_dut0 (
        .CLK(clk), .RN(rn), .START(start[0]), .ABORT(abort[0]),
        .A1(a1_0), .A2(a2_0), .ZN(zn0), .BUSY(busy_0), .DONE(done_0), .PASS(pass_0),
        .ERRCNT(ec_0), .FAILMAP(fm_0), .VDD(vdd), .VSS(vss)
    );

    nand2_array_bist_ctrl #(.N(4), .SETTLE_CYC(0), .ERRW(3)) u_dut1 (
        .CLK(clk), .RN(rn), .START(start[1]), .ABORT(abort[1]),
        .A1(a1_1), .A2(a2_1), .ZN(zn1), .BUSY(busy_1), .DONE(done_1), .PASS(pass_1),
        .ERRCNT(ec_1), .FAILMAP(fm_1), .VDD(vdd), .VSS(vss)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic int settle_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic int sat_of(input int d);
        return (d == 0) ? 255 : 7;
    endfunction

    // Packed view: {busy, done, pass, A1, A2, FAILMAP, ERRCNT(8)}.
    function automatic logic [31:0] observe(input int d);
        if (d == 0) return {9'b0, busy_0, done_0, pass_0, a1_0, a2_0, fm_0, ec_0};
        return {9'b0, busy_1, done_1, pass_1, a1_1, a2_1, fm_1, 5'b0, ec_1};
    endfunction

    // Faulty bank: stuck-at-0 cells in m0, stuck-at-1 cells in m1.
    function automatic logic [3:0] bank_zn(input logic a1, input logic a2,
                                           input logic [3:0] m0, input logic [3:0] m1);
        logic [3:0] good;
        good = {4{~(a1 & a2)}};
        return (good & ~m0) | m1;
    endfunction

    // Expected outputs in cycle k after the START-sampling edge.
    function automatic logic [31:0] expect_k(input int d, input int k, input logic [3:0] m0,
                                             input logic [3:0] m1, input int ka);
        int len, t, npat, sum, ec, p;
        logic busy, done, pass, a1, a2, aborted;
        logic [3:0] fm, good, mis;
        len = settle_of(d) + 2;
        t = 4 * len;
        busy = 0; done = 0; pass = 0; a1 = 0; a2 = 0; fm = '0; sum = 0;
        aborted = (ka >= 0) && (ka < t);
        if (aborted && k > ka) begin
            npat = ka / len;
        end else if (k < t) begin
            npat = k / len;
            busy = 1;
            a1 = npat[1];
            a2 = npat[0];
        end else begin
            npat = 4;
            done = (k == t);
            a1 = (k == t);
            a2 = (k == t);
        end
        for (p = 0; p < npat; p++) begin
            good = {4{~(p[1] & p[0])}};
            mis = bank_zn(p[1], p[0], m0, m1) ^ good;
            fm = fm | mis;
            sum += $countones(mis);
        end
        ec = (sum > sat_of(d)) ? sat_of(d) : sum;
        if (!aborted && k >= t) pass = (fm == 4'b0);
        return {9'b0, busy, done, pass, {4{a1}}, {4{a2}}, fm, 8'(ec)};
    endfunction

    // One run: ka = cycle ABORT is high, kb = cycle of a stray START, kr = cycle RN drops.
    task automatic run(input int d, input logic [3:0] m0, input logic [3:0] m1,
                       input int ka, input int kb, input int kr, input bit both);
        int len, t, last, pat;
        logic [3:0] v;
        len = settle_of(d) + 2;
        t = 4 * len;
        last = (ka >= 0 && ka < t) ? ka + 3 : t + 1;
        start[d] = 1'b1;
        abort[d] = both;
        for (int k = 0; k <= last; k++) begin
            @(posedge clk);
            #1;
            start[d] = (k == kb);
            abort[d] = (k == ka);
            check_eq($sformatf("d%0d_cycle%0d", d, k), observe(d), expect_k(d, k, m0, m1, ka));
            pat = k / len;
            // ZN is only meaningful in the SAMPLE cycle; elsewhere it is noise.
            if (k < t && (k % len) == len - 1 && !(ka >= 0 && k > ka))
                v = bank_zn(pat[1], pat[0], m0, m1);
            else
                v = 4'($urandom);
            if (d == 0) zn0 = v; else zn1 = v;
            if (k == kr) begin
                start[d] = 1'b0;
                abort[d] = 1'b0;
                #2 rn = 1'b0;
                #1 check_eq("reset_async", observe(d), 32'h0);
                @(posedge clk);
                #1 check_eq("reset_held", observe(d), 32'h0);
                rn = 1'b1;
                break;
            end
        end
        start[d] = 1'b0;
        abort[d] = 1'b0;
    endtask

    initial begin
        int d, len, t, ka, kb;
        logic [3:0] m0, m1;
        #12;
        check_eq("reset_dut0", observe(0), 32'h0);
        check_eq("reset_dut1", observe(1), 32'h0);
        @(posedge clk);
        #1 rn = 1'b1;

        // ABORT alone in IDLE does nothing.
        abort[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_eq("abort_idle", observe(0), 32'h0);
        abort[0] = 1'b0;

        run(0, 4'h0, 4'h0, -1, 2, -1, 1'b0);
        check_eq("good_pass", 32'(pass_0), 32'd1);
        check_eq("good_errcnt", 32'(ec_0), 32'd0);
        run(0, 4'h0, 4'h0, -1, -1, 9, 1'b0);
        run(0, 4'h0, 4'h0, -1, -1, -1, 1'b1);
        run(0, 4'h0, 4'b0100, -1, 5, -1, 1'b0);
        check_eq("sa1_failmap", 32'(fm_0), 32'h4);
        check_eq("sa1_errcnt", 32'(ec_0), 32'd1);
        check_eq("sa1_pass", 32'(pass_0), 32'd0);
        run(0, 4'hF, 4'h0, 16, 16, -1, 1'b0);
        check_eq("sa0_errcnt", 32'(ec_0), 32'd12);
        check_eq("sa0_failmap", 32'(fm_0), 32'hF);
        run(1, 4'hF, 4'h0, -1, 3, -1, 1'b0);
        check_eq("sa0_sat_errcnt", 32'(ec_1), 32'd7);
        run(1, 4'h0, 4'h0, -1, -1, -1, 1'b0);
        check_eq("settle0_pass", 32'(pass_1), 32'd1);
        run(0, 4'h0, 4'h0, 6, 3, -1, 1'b0);
        check_eq("abort_pass", 32'(pass_0), 32'd0);
        run(0, 4'h0, 4'h0, -1, -1, -1, 1'b0);

        for (int i = 0; i < 8; i++) begin
            d = i % 2;
            len = settle_of(d) + 2;
            t = 4 * len;
            m0 = 4'($urandom);
            m1 = 4'($urandom) & ~m0;
            ka = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, t)) : -1;
            if (ka >= 0 && ka < t)
                kb = (ka == 0) ? -1 : int'($urandom_range(1, ka));
            else
                kb = int'($urandom_range(1, t));
            run(d, m0, m1, ka, kb, -1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
